py_rx_acl_buf_ctrl: RTL

//  Receive-side ACL payload buffer: link controller (lnctrl) writes decoded payload words into a fill bank.

---
 rtl/py_rxacl_pkg.sv | 12 +
 rtl/py_rxacl_arq_eval.sv | 31 +++
 rtl/sram256x32_1p.sv | 20 ++
 rtl/py_rx_acl_buf_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/py_rxacl_pkg.sv
// Shared widths and enumerations for the RX ACL ping-pong payload buffer.
package py_rxacl_pkg;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 10;

    typedef enum logic [1:0] {IDLE, RX, EVAL} state_t;

    typedef enum logic [1:0] {CRC, OVF, DUP, BUSY} drop_rsn_t;

endpackage

// File: rtl/py_rxacl_arq_eval.sv
// End-of-payload decision: accept, or drop with the first matching reason.
module py_rxacl_arq_eval
    import py_rxacl_pkg::*;
(
    input  logic      crcok,
    input  logic      ovf,
    input  logic      seqn,
    input  logic      seqn_vld,
    input  logic      last_seqn,
    input  logic      bsm_rdy,
    input  logic      bsm_rel,
    output logic      accept,
    output logic      drop,
    output drop_rsn_t reason
);

    always_comb begin
        accept = 1'b0;
        drop   = 1'b1;
        reason = CRC;
        if (!crcok)                           reason = CRC;
        else if (ovf)                         reason = OVF;
        else if (seqn_vld && seqn == last_seqn) reason = DUP;
        else if (bsm_rdy && !bsm_rel)         reason = BUSY;  // release in the same cycle frees the bank
        else begin
            accept = 1'b1;
            drop   = 1'b0;
        end
    end

endmodule

// File: rtl/sram256x32_1p.sv
// Single-port 256x32 synchronous SRAM: write when CS&WE, registered read when CS&!WE.
module sram256x32_1p (
    input  logic        CLK,
    input  logic        CS,
    input  logic        WE,
    input  logic [7:0]  A,
    input  logic [31:0] DIN,
    output logic [31:0] DOUT
);

    logic [31:0] mem [256];

    always_ff @(posedge CLK) begin
        if (CS) begin
            if (WE) mem[A] <= DIN;
            else    DOUT   <= mem[A];
        end
    end

endmodule

// File: rtl/py_rx_acl_buf_ctrl.sv
// RX ACL payload buffer: lnctrl fills one SRAM bank while bsm reads the other; commit swaps banks.
// Optional macro PY_RXACL_FLOW_EN: flow follows host-bank occupancy instead of being tied high.
module py_rx_acl_buf_ctrl
    import py_rxacl_pkg::*;
(
    input  logic          clk_6M,
    input  logic          rstz,
    input  logic          lnctrl_start,
    input  logic          lnctrl_we,
    input  logic [DW-1:0] lnctrl_din,
    input  logic          lnctrl_done,
    input  logic          lnctrl_crcok,
    input  logic          lnctrl_seqn,
    input  logic [LW-1:0] lnctrl_len,
    input  logic [AW-1:0] bsm_addr,
    input  logic          bsm_cs,
    input  logic          bsm_rel,
    output logic [DW-1:0] bsm_dout,
    output logic          bsm_rdy,
    output logic [LW-1:0] bsm_len,
    output logic          arqn,
    output logic          rx_acc,
    output logic          rx_drop,
    output logic          flow
);

    state_t        state, state_nxt;
    logic          fsel;
    logic [AW:0]   wptr;
    logic          ovf;
    logic          seqn_vld, last_seqn;
    logic          crcok_q, seqn_q;
    logic [LW-1:0] len_q;
    logic          rd_pend, rd_bank;
    logic          wr_en, eval_go, rdy_nxt;
    logic          accept, drop;
    drop_rsn_t     reason;

    logic          cs0, we0, cs1, we1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1, q0, q1;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (lnctrl_start) state_nxt = RX;
            RX:      if (!lnctrl_start && lnctrl_done) state_nxt = EVAL;
            EVAL:    state_nxt = lnctrl_start ? RX : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign wr_en   = (state == RX) && lnctrl_we && !lnctrl_start && !wptr[AW];
    assign eval_go = (state == EVAL) && !lnctrl_start;

    py_rxacl_arq_eval u_eval (
        .crcok     (crcok_q),
        .ovf       (ovf),
        .seqn      (seqn_q),
        .seqn_vld  (seqn_vld),
        .last_seqn (last_seqn),
        .bsm_rdy   (bsm_rdy),
        .bsm_rel   (bsm_rel),
        .accept    (accept),
        .drop      (drop),
        .reason    (reason)
    );

    always_comb begin
        rdy_nxt = bsm_rdy;
        if (bsm_rel) rdy_nxt = 1'b0;
        if (eval_go && accept) rdy_nxt = 1'b1;
    end

    always_ff @(posedge clk_6M) begin
        if (!rstz) begin
            state     <= IDLE;
            fsel      <= 1'b0;
            wptr      <= '0;
            ovf       <= 1'b0;
            bsm_rdy   <= 1'b0;
            bsm_len   <= '0;
            arqn      <= 1'b0;
            seqn_vld  <= 1'b0;
            last_seqn <= 1'b0;
            rx_acc    <= 1'b0;
            rx_drop   <= 1'b0;
            crcok_q   <= 1'b0;
            seqn_q    <= 1'b0;
            len_q     <= '0;
        end else begin
            state   <= state_nxt;
            bsm_rdy <= rdy_nxt;
            rx_acc  <= 1'b0;
            rx_drop <= 1'b0;
            if (lnctrl_start) begin
                wptr <= '0;
                ovf  <= 1'b0;
            end else if (state == RX && lnctrl_we) begin
                if (wptr[AW]) ovf <= 1'b1;
                else          wptr <= wptr + 1'b1;
            end
            if (state == RX && lnctrl_done && !lnctrl_start) begin
                crcok_q <= lnctrl_crcok;
                seqn_q  <= lnctrl_seqn;
                len_q   <= lnctrl_len;
            end
            if (eval_go) begin
                arqn    <= accept | (reason == DUP);
                rx_acc  <= accept;
                rx_drop <= drop;
                if (accept) begin
                    fsel      <= ~fsel;
                    bsm_len   <= len_q;
                    last_seqn <= seqn_q;
                    seqn_vld  <= 1'b1;
                end
            end
        end
    end

    // Bank fsel is the fill bank; the other is host, read-only from bsm.
    always_comb begin
        cs0 = fsel ? bsm_cs   : wr_en;
        we0 = fsel ? 1'b0     : wr_en;
        a0  = fsel ? bsm_addr : wptr[AW-1:0];
        d0  = fsel ? '0       : lnctrl_din;
        cs1 = fsel ? wr_en    : bsm_cs;
        we1 = fsel ? wr_en    : 1'b0;
        a1  = fsel ? wptr[AW-1:0] : bsm_addr;
        d1  = fsel ? lnctrl_din   : '0;
    end

    sram256x32_1p u_bank0 (.CLK(clk_6M), .CS(cs0), .WE(we0), .A(a0), .DIN(d0), .DOUT(q0));
    sram256x32_1p u_bank1 (.CLK(clk_6M), .CS(cs1), .WE(we1), .A(a1), .DIN(d1), .DOUT(q1));

    // Bank is captured with the request so a swap between SRAM read and output stage is harmless.
    always_ff @(posedge clk_6M) begin
        if (!rstz) begin
            rd_pend  <= 1'b0;
            rd_bank  <= 1'b0;
            bsm_dout <= '0;
        end else begin
            rd_pend <= bsm_cs;
            rd_bank <= ~fsel;
            if (rd_pend) bsm_dout <= rd_bank ? q1 : q0;
        end
    end

`ifdef PY_RXACL_FLOW_EN
    always_ff @(posedge clk_6M) begin
        if (!rstz) flow <= 1'b1;
        else       flow <= ~rdy_nxt;
    end
`else
    assign flow = 1'b1;
`endif

endmodule
